// File: rtl/cr_tlvp_prs.sv
// TLV parser: delimits TLVs in an FWFT 64-bit word stream, tags sot/eot/ordern/typen, routes whole TLVs to pt or usr.
// Optional header BIP2 check under `TLVP_PRS_BIP2_CHK_EN; one-cycle latency from ib_rd to the write strobe.
module cr_tlvp_prs #(
  parameter  int ORD_W = 5,
  parameter  int LEN_W = 16,
  localparam int TLV_W = 1 + ORD_W + 8 + 3 + 90
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ib_empty,
  input  logic [89:0]      ib_data,
  output logic             ib_rd,
  input  logic [31:0]      usr_type_en,
  input  logic             pt_ob_afull,
  output logic             pt_ob_wr,
  output logic [TLV_W-1:0] pt_ob_tlv,
  input  logic             usr_ib_afull,
  output logic             usr_ib_wr,
  output logic [TLV_W-1:0] usr_ib_tlv,
  output logic             err_trunc,
  output logic             err_ord_sat,
  output logic             err_bip2
);

  typedef enum logic {HDR, BODY} state_t;

  localparam logic [ORD_W-1:0] ORD_ONE = ORD_W'(1);
  localparam logic [ORD_W-1:0] ORD_MAX = '1;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem_cnt, rem_nxt;
  logic [ORD_W-1:0] ordern, ord_nxt;
  logic [7:0]       typ_q, typ_nxt, typ_tag;
  logic             route_usr, route_nxt;

  logic             tlast;
  logic [63:0]      tdata;
  logic [7:0]       hdr_typ;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_usr;
  logic             sot, eot, wr_usr, trunc, ord_sat;
  logic [TLV_W-1:0] tlv_nxt;

  assign tlast   = ib_data[89];
  assign tdata   = ib_data[63:0];
  assign hdr_typ = tdata[7:0];
  assign hdr_len = tdata[8 +: LEN_W];
  assign hdr_usr = (hdr_typ < 8'd32) && usr_type_en[hdr_typ[4:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR;
      rem_cnt   <= '0;
      ordern    <= ORD_ONE;
      typ_q     <= '0;
      route_usr <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem_cnt   <= rem_nxt;
      ordern    <= ord_nxt;
      typ_q     <= typ_nxt;
      route_usr <= route_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_cnt;
    ord_nxt   = ordern;
    typ_nxt   = typ_q;
    route_nxt = route_usr;
    sot       = 1'b0;
    eot       = 1'b0;
    trunc     = 1'b0;
    ord_sat   = 1'b0;
    wr_usr    = route_usr;
    // A header may go either way, so it waits until both outputs have room.
    if (state == HDR) ib_rd = ~ib_empty & ~pt_ob_afull & ~usr_ib_afull;
    else              ib_rd = ~ib_empty & ~(route_usr ? usr_ib_afull : pt_ob_afull);

    if (ib_rd) begin
      if (state == HDR) begin
        sot       = 1'b1;
        wr_usr    = hdr_usr;
        route_nxt = hdr_usr;
        typ_nxt   = hdr_typ;
        rem_nxt   = (hdr_len == '0) ? '0 : hdr_len - LEN_W'(1);
        if (hdr_len <= LEN_W'(1) || tlast) eot = 1'b1;
        else state_nxt = BODY;
      end else begin
        rem_nxt = rem_cnt - LEN_W'(1);
        if (rem_cnt <= LEN_W'(1)) begin
          eot       = 1'b1;
          state_nxt = HDR;
        end else if (tlast) begin
          eot       = 1'b1;
          trunc     = 1'b1;
          rem_nxt   = '0;
          state_nxt = HDR;
        end
      end
      if (eot) begin
        if (tlast) begin
          ord_nxt = ORD_ONE;
        end else if (ordern != ORD_MAX) begin
          ord_nxt = ordern + ORD_ONE;
          ord_sat = (ord_nxt == ORD_MAX);
        end
      end
    end
  end

  assign typ_tag = (state == HDR) ? hdr_typ : typ_q;
  // The flag triplet carries a copy of tlast; the full input word follows untouched.
  assign tlv_nxt = {1'b0, ordern, typ_tag, sot, eot, tlast, ib_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_ob_wr    <= 1'b0;
      usr_ib_wr   <= 1'b0;
      pt_ob_tlv   <= '0;
      usr_ib_tlv  <= '0;
      err_trunc   <= 1'b0;
      err_ord_sat <= 1'b0;
    end else begin
      pt_ob_wr    <= ib_rd & ~wr_usr;
      usr_ib_wr   <= ib_rd & wr_usr;
      err_trunc   <= trunc;
      err_ord_sat <= ord_sat;
      if (ib_rd & ~wr_usr) pt_ob_tlv  <= tlv_nxt;
      if (ib_rd & wr_usr)  usr_ib_tlv <= tlv_nxt;
    end
  end

`ifdef TLVP_PRS_BIP2_CHK_EN
  logic bip_b0, bip_b1, bip_bad;

  always_comb begin
    bip_b0 = 1'b0;
    bip_b1 = 1'b0;
    for (int i = 0; i < 62; i += 2) begin
      bip_b0 = bip_b0 ^ tdata[i];
      bip_b1 = bip_b1 ^ tdata[i+1];
    end
    bip_bad = ({bip_b1, bip_b0} != tdata[63:62]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_bip2 <= 1'b0;
    else        err_bip2 <= ib_rd & (state == HDR) & bip_bad;
  end
`else
  assign err_bip2 = 1'b0;
`endif

endmodule

// File: tb/tb_cr_tlvp_prs.sv
// Bench for cr_tlvp_prs: vector table through an FWFT FIFO model, scoreboard on the outputs, plus backpressure/saturation sequences.
module tb_cr_tlvp_prs;

  localparam int TW  = 1 + 5 + 8 + 3 + 90;
  localparam int TW2 = 1 + 2 + 8 + 3 + 90;
`ifdef TLVP_PRS_BIP2_CHK_EN
  localparam logic BIPX = 1'b1;
`else
  localparam logic BIPX = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] en;
    logic [89:0] din;
    logic        usr;
    logic [4:0]  ord;
    logic [7:0]  typ;
    logic        sot, eot, trunc, bip;
  } vec_t;

  typedef struct packed {
    logic          usr;
    logic [TW-1:0] tlv;
    logic          trunc, sat, bip;
  } exp_t;

  logic clk, rst_n;
  logic ib_empty, ib_rd, pt_ob_afull, usr_ib_afull;
  logic [89:0] ib_data;
  logic [31:0] usr_type_en;
  logic pt_ob_wr, usr_ib_wr, err_trunc, err_ord_sat, err_bip2;
  logic [TW-1:0] pt_ob_tlv, usr_ib_tlv;

  logic ib_empty2, ib_rd2, pt_ob_wr2, usr_ib_wr2, err_trunc2, err_ord_sat2, err_bip22;
  logic [89:0] ib_data2;
  logic [TW2-1:0] pt_ob_tlv2, usr_ib_tlv2;

  int n_vec = 0, n_err = 0;
  int both_cnt = 0, rd_afull_cnt = 0;
  bit tog_en = 0;
  bit pop_now;
  logic [89:0] in_q[$];
  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[17];

  cr_tlvp_prs dut (
    .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty), .ib_data(ib_data), .ib_rd(ib_rd),
    .usr_type_en(usr_type_en), .pt_ob_afull(pt_ob_afull), .pt_ob_wr(pt_ob_wr), .pt_ob_tlv(pt_ob_tlv),
    .usr_ib_afull(usr_ib_afull), .usr_ib_wr(usr_ib_wr), .usr_ib_tlv(usr_ib_tlv),
    .err_trunc(err_trunc), .err_ord_sat(err_ord_sat), .err_bip2(err_bip2)
  );

  cr_tlvp_prs #(.ORD_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ib_empty(ib_empty2), .ib_data(ib_data2), .ib_rd(ib_rd2),
    .usr_type_en(32'd0), .pt_ob_afull(1'b0), .pt_ob_wr(pt_ob_wr2), .pt_ob_tlv(pt_ob_tlv2),
    .usr_ib_afull(1'b0), .usr_ib_wr(usr_ib_wr2), .usr_ib_tlv(usr_ib_tlv2),
    .err_trunc(err_trunc2), .err_ord_sat(err_ord_sat2), .err_bip2(err_bip22)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] bip2(input logic [63:0] d);
    logic b0, b1;
    b0 = 1'b0;
    b1 = 1'b0;
    for (int i = 0; i < 62; i++) begin
      if (i % 2 == 0) b0 = b0 ^ d[i];
      else            b1 = b1 ^ d[i];
    end
    return {b1, b0};
  endfunction

  function automatic logic [89:0] hdr(input logic [7:0] t, input logic [15:0] l, input logic tl);
    logic [63:0] d;
    d = {2'b00, 6'h15, t, l, t, l, t};
    d[63:62] = bip2(d);
    return {tl, 1'b1, t ^ 8'hF0, l, d};
  endfunction

  function automatic logic [89:0] hdr_bad(input logic [7:0] t, input logic [15:0] l, input logic tl);
    logic [89:0] w;
    w = hdr(t, l, tl);
    w[63:62] = ~w[63:62];
    return w;
  endfunction

  function automatic logic [89:0] body(input int k, input logic tl);
    return {tl, 25'(k), 32'hB0D1_C0DE, 32'(k * 3 + 1)};
  endfunction

  function automatic vec_t mk(input logic [31:0] en, input logic [89:0] din, input logic usr,
                              input logic [4:0] ord, input logic [7:0] typ, input logic sot,
                              input logic eot, input logic trunc, input logic bip);
    vec_t v;
    v.en = en; v.din = din; v.usr = usr; v.ord = ord; v.typ = typ;
    v.sot = sot; v.eot = eot; v.trunc = trunc; v.bip = bip;
    return v;
  endfunction

  task automatic push(input logic [89:0] din, input logic usr, input logic [4:0] ord,
                      input logic [7:0] typ, input logic sot, input logic eot,
                      input logic trunc, input logic bip);
    exp_t x;
    x.usr = usr;
    x.tlv = {1'b0, ord, typ, sot, eot, din[89], din};
    x.trunc = trunc;
    x.sat = 1'b0;
    x.bip = bip;
    in_q.push_back(din);
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 256'(exp_q.size()), 256'd0);
  endtask

  // FWFT input FIFO model
  initial begin
    ib_empty = 1'b1;
    ib_data  = '0;
    forever begin
      @(posedge clk);
      pop_now = rst_n && ib_rd && (in_q.size() > 0);
      #1;
      if (pop_now) void'(in_q.pop_front());
      ib_empty = (in_q.size() == 0);
      ib_data  = ib_empty ? '0 : in_q[0];
    end
  end

  initial begin
    pt_ob_afull = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pt_ob_afull = tog_en ? ~pt_ob_afull : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pt_ob_wr && usr_ib_wr) both_cnt++;
      if (ib_rd && pt_ob_afull) rd_afull_cnt++;
      if (pt_ob_wr || usr_ib_wr) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 256'({pt_ob_wr, usr_ib_wr}), 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word", 256'({usr_ib_wr, usr_ib_wr ? usr_ib_tlv : pt_ob_tlv, err_trunc, err_ord_sat, err_bip2}),
              256'({e.usr, e.tlv, e.trunc, e.sat, e.bip}));
        end
      end else if (err_trunc || err_ord_sat || err_bip2) begin
        chk("stray_err", 256'({err_trunc, err_ord_sat, err_bip2}), 256'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] so2[5];
    logic       sat2[5];
    so2  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sat2 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    usr_type_en = '0;
    usr_ib_afull = 1'b0;
    ib_empty2 = 1'b1;
    ib_data2 = '0;
    repeat (3) @(negedge clk);
    chk("reset", 256'({ib_rd, pt_ob_wr, usr_ib_wr, pt_ob_tlv, usr_ib_tlv, err_trunc, err_ord_sat, err_bip2}), 256'd0);
    chk("reset2", 256'({pt_ob_wr2, usr_ib_wr2, pt_ob_tlv2, err_ord_sat2}), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //          en          din                     usr ord typ   sot eot trc bip
    tbl[0]  = mk(32'h0,     hdr(8'd5, 16'd3, 0),    0,  1,  8'd5,  1,  0,  0,  0);
    tbl[1]  = mk(32'h0,     body(1, 0),             0,  1,  8'd5,  0,  0,  0,  0);
    tbl[2]  = mk(32'h0,     body(2, 0),             0,  1,  8'd5,  0,  1,  0,  0);
    tbl[3]  = mk(32'h0,     hdr(8'd9, 16'd1, 1),    0,  2,  8'd9,  1,  1,  0,  0);
    tbl[4]  = mk(32'h0,     hdr(8'd7, 16'd1, 1),    0,  1,  8'd7,  1,  1,  0,  0);
    tbl[5]  = mk(32'h200,   hdr(8'd5, 16'd2, 0),    0,  1,  8'd5,  1,  0,  0,  0);
    tbl[6]  = mk(32'h200,   body(3, 0),             0,  1,  8'd5,  0,  1,  0,  0);
    tbl[7]  = mk(32'h200,   hdr(8'd9, 16'd2, 0),    1,  2,  8'd9,  1,  0,  0,  0);
    tbl[8]  = mk(32'h200,   body(4, 1),             1,  2,  8'd9,  0,  1,  0,  0);
    tbl[9]  = mk(32'h200,   hdr(8'd41, 16'd1, 1),   0,  1,  8'd41, 1,  1,  0,  0);
    tbl[10] = mk(32'h200,   hdr(8'd3, 16'd4, 0),    0,  1,  8'd3,  1,  0,  0,  0);
    tbl[11] = mk(32'h200,   body(5, 1),             0,  1,  8'd3,  0,  1,  1,  0);
    tbl[12] = mk(32'h200,   hdr(8'd9, 16'd1, 0),    1,  1,  8'd9,  1,  1,  0,  0);
    tbl[13] = mk(32'h200,   hdr(8'd6, 16'd0, 0),    0,  2,  8'd6,  1,  1,  0,  0);
    tbl[14] = mk(32'h200,   hdr(8'd6, 16'd5, 1),    0,  3,  8'd6,  1,  1,  0,  0);
    tbl[15] = mk(32'h200,   hdr_bad(8'd6, 16'd1, 1),0,  1,  8'd6,  1,  1,  0,  BIPX);
    tbl[16] = mk(32'h200,   hdr(8'd6, 16'd1, 1),    0,  1,  8'd6,  1,  1,  0,  0);

    for (int i = 0; i < 17; i++) begin
      if (i == 0 || tbl[i].en != usr_type_en) begin
        wait_drain();
        usr_type_en = tbl[i].en;
      end
      push(tbl[i].din, tbl[i].usr, tbl[i].ord, tbl[i].typ, tbl[i].sot, tbl[i].eot, tbl[i].trunc, tbl[i].bip);
    end
    wait_drain();

    // usr afull stalls a header even when it routes to pt
    usr_ib_afull = 1'b1;
    push(hdr(8'd5, 16'd1, 1), 0, 1, 8'd5, 1, 1, 0, 0);
    repeat (4) @(negedge clk);
    chk("hdr_stall_usr_afull", 256'({ib_rd, 8'(exp_q.size())}), 256'({1'b0, 8'd1}));
    usr_ib_afull = 1'b0;
    wait_drain();

    // len=8 TLV under pt afull toggling every cycle
    tog_en = 1'b1;
    push(hdr(8'd5, 16'd8, 0), 0, 1, 8'd5, 1, 0, 0, 0);
    for (int k = 10; k < 17; k++)
      push(body(k, k == 16), 0, 1, 8'd5, 0, k == 16, 0, 0);
    wait_drain();
    tog_en = 1'b0;
    chk("rd_while_afull", 256'(rd_afull_cnt), 256'd0);
    chk("both_wr", 256'(both_cnt), 256'd0);

    // ORD_W=2 saturation on the second instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ib_data2 = hdr(8'd1, 16'd1, 0);
      ib_empty2 = 1'b0;
      @(posedge clk);
      #1 ib_empty2 = 1'b1;
      @(negedge clk);
      chk($sformatf("ord_sat_%0d", i), 256'({pt_ob_wr2, pt_ob_tlv2[TW2-2 -: 2], err_ord_sat2}),
          256'({1'b1, so2[i], sat2[i]}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
